// File: rtl/serial_deserializer_pkg.sv
// Shared definitions for the serial byte link: frame state encoding and the
// handshake-fire helper, so transmitter and receiver agree on both.
package serial_deserializer_pkg;

    // Frame-level states shared by both ends of the link.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // A transfer happens on any edge where the producer offers and the consumer takes.
    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Pin/consumer-side bundle of the deserializer.
// Handshake: the word on o_data_out transfers on every rising edge where
// o_out_valid and i_out_ready are both 1; o_out_valid never drops without
// such a transfer, and o_data_out holds steady while o_out_valid=1 and
// i_out_ready=0.
interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             i_enable;
    logic             i_serial_in;
    logic             i_frame_start;
    logic             i_out_ready;
    logic             i_err_clr;
    logic [WIDTH-1:0] o_data_out;
    logic             o_out_valid;
    logic             o_busy;
    logic             o_overrun;
    logic             o_frame_err;

    // Driver / consumer side.
    modport master (
        output i_enable, i_serial_in, i_frame_start, i_out_ready, i_err_clr,
        input  o_data_out, o_out_valid, o_busy, o_overrun, o_frame_err
    );

    // Deserializer side.
    modport slave (
        input  i_enable, i_serial_in, i_frame_start, i_out_ready, i_err_clr,
        output o_data_out, o_out_valid, o_busy, o_overrun, o_frame_err
    );
endinterface

// File: rtl/serial_bit_counter.sv
// Bit position counter for one serial frame: load to 1 on the first bit,
// increment per bit, clear at frame end, flag the last bit position.
module serial_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,     // synchronous, active low
    input  logic                     i_load1,
    input  logic                     i_inc,
    input  logic                     i_clear,
    output logic [$clog2(WIDTH)-1:0] o_count,
    output logic                     o_tc
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] r_count;

    // Clear wins over load, load wins over increment.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= CNT_W'(1);
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_deserializer.sv
// Receive end of the serial byte link: gathers WIDTH bits per frame into a
// word, hands it to the consumer through a one-word buffer, and keeps
// sticky overrun / framing-error flags.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,      // synchronous, active low
    serial_deserializer_if.slave     bus,
    output state_t                   o_state,    // debug: frame FSM state
    output logic [$clog2(WIDTH)-1:0] o_bit_cnt   // debug: bits captured so far
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_start;       // first bit of a frame (fresh or restart)
    logic             w_shift;       // subsequent bit of the current frame
    logic             w_complete;    // this bit finishes the frame
    logic             w_abort;       // frame start seen mid-frame
    logic [CNT_W-1:0] w_bit_cnt;
    logic             w_tc;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_first_word;
    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_frame_err;
    logic             w_fire;
    logic             w_accept;
    logic             w_drop;

    serial_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load1 (w_start),
        .i_inc   (w_shift & ~w_tc),
        .i_clear (w_complete),
        .o_count (w_bit_cnt),
        .o_tc    (w_tc)
    );

    // Frame state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-bit decode; a frame start always restarts the frame.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_enable && bus.i_frame_start) begin
                    w_start      = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.i_enable) begin
                    if (bus.i_frame_start) begin
                        w_start = 1'b1;
                        w_abort = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                        if (w_tc) begin
                            w_complete   = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Word assembly: MSB-first shifts left so bit 0 ends up in the MSB.
    always_comb begin
        w_first_word = '0;
        w_shift_next = '0;
        if (MSB_FIRST) begin
            w_first_word = {{(WIDTH-1){1'b0}}, bus.i_serial_in};
            w_shift_next = {r_shift[WIDTH-2:0], bus.i_serial_in};
        end else begin
            w_first_word = {bus.i_serial_in, {(WIDTH-1){1'b0}}};
            w_shift_next = {bus.i_serial_in, r_shift[WIDTH-1:1]};
        end
    end

    // Shift register; a restart discards any partial word.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_shift <= '0;
        end else if (w_start) begin
            r_shift <= w_first_word;
        end else if (w_shift) begin
            r_shift <= w_shift_next;
        end
    end

    // A completed word is taken if the buffer is empty or drains on this edge.
    assign w_fire   = hs_fire(r_out_valid, bus.i_out_ready);
    assign w_accept = w_complete & (~r_out_valid | bus.i_out_ready);
    assign w_drop   = w_complete & ~w_accept;

    // One-word output buffer; data holds its last value after a consume.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_data_out  <= w_shift_next;
            r_out_valid <= 1'b1;
        end else if (w_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set on the same edge as a clear wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_drop  | (r_overrun   & ~bus.i_err_clr);
            r_frame_err <= w_abort | (r_frame_err & ~bus.i_err_clr);
        end
    end

    assign bus.o_data_out  = r_data_out;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_busy      = (r_state == ST_SHIFT);
    assign bus.o_overrun   = r_overrun;
    assign bus.o_frame_err = r_frame_err;
    assign o_state         = r_state;
    assign o_bit_cnt       = w_bit_cnt;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: an MSB-first and an LSB-first instance share
// the same stimulus; a frame-level reference model predicts every output.
module tb_serial_deserializer;
    import serial_deserializer_pkg::*;

    localparam int W = 8;

    logic   clk;
    logic   rst_n;
    state_t state0, state1;
    logic [2:0] cnt0, cnt1;

    serial_deserializer_if #(.WIDTH(W)) bus0 ();
    serial_deserializer_if #(.WIDTH(W)) bus1 ();

    assign bus1.i_enable      = bus0.i_enable;
    assign bus1.i_serial_in   = bus0.i_serial_in;
    assign bus1.i_frame_start = bus0.i_frame_start;
    assign bus1.i_out_ready   = bus0.i_out_ready;
    assign bus1.i_err_clr     = bus0.i_err_clr;

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .i_clk(clk), .i_rst(rst_n), .bus(bus0.slave), .o_state(state0), .o_bit_cnt(cnt0)
    );
    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(clk), .i_rst(rst_n), .bus(bus1.slave), .o_state(state1), .o_bit_cnt(cnt1)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bits of the frame in arrival order, one buffered word
    // (stored in arrival order, first bit at the MSB), sticky flags.
    bit         m_in_frame = 1'b0;
    logic       m_bits[$];
    logic [W-1:0] m_data = '0;
    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;
    bit         m_ferr  = 1'b0;

    function automatic logic [W-1:0] rev_bits(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit sin, input bit fs,
                              input bit rdy, input bit clr);
        bit           done;
        bit           ovr_set;
        bit           ferr_set;
        logic [W-1:0] word;
        done = 0; ovr_set = 0; ferr_set = 0; word = '0;
        if (!r) begin
            m_in_frame = 0; m_bits.delete(); m_data = '0;
            m_valid = 0; m_ovr = 0; m_ferr = 0;
            return;
        end
        if (en && fs) begin
            if (m_in_frame) ferr_set = 1;
            m_bits.delete();
            m_bits.push_back(sin);
            m_in_frame = 1;
        end else if (en && m_in_frame) begin
            m_bits.push_back(sin);
            if (m_bits.size() == W) begin
                done = 1;
                for (int i = 0; i < W; i++) word = (word << 1) | W'(m_bits[i]);
                m_bits.delete();
                m_in_frame = 0;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = word;
                m_valid = 1;
            end else begin
                ovr_set = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_ovr  = ovr_set  | (m_ovr  & ~clr);
        m_ferr = ferr_set | (m_ferr & ~clr);
    endtask

    task automatic check_all();
        chk("busy_msb",   32'(bus0.o_busy),      32'(m_in_frame));
        chk("busy_lsb",   32'(bus1.o_busy),      32'(m_in_frame));
        chk("valid_msb",  32'(bus0.o_out_valid), 32'(m_valid));
        chk("valid_lsb",  32'(bus1.o_out_valid), 32'(m_valid));
        chk("overrun",    32'(bus0.o_overrun),   32'(m_ovr));
        chk("frame_err",  32'(bus0.o_frame_err), 32'(m_ferr));
        chk("data_msb",   32'(bus0.o_data_out),  32'(m_data));
        chk("data_lsb",   32'(bus1.o_data_out),  32'(rev_bits(m_data)));
        chk("bit_cnt",    32'(cnt0),             32'(m_bits.size()));
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 after.
    task automatic cycle(input bit r, input bit en, input bit sin, input bit fs,
                         input bit rdy, input bit clr);
        rst_n              = r;
        bus0.i_enable      = en;
        bus0.i_serial_in   = sin;
        bus0.i_frame_start = fs;
        bus0.i_out_ready   = rdy;
        bus0.i_err_clr     = clr;
        @(posedge clk);
        model_step(r, en, sin, fs, rdy, clr);
        #1;
        check_all();
    endtask

    // Send a full frame, first bit = word[W-1].
    task automatic send_word(input logic [W-1:0] word, input bit rdy);
        for (int i = 0; i < W; i++) cycle(1, 1, word[W-1-i], i == 0, rdy, 0);
    endtask

    initial begin
        logic [W-1:0] w;
        bit r, en, sin, fs, rdy, clr;

        // 1. Reset with toggling serial input
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0);
        chk("t1_data", 32'(bus0.o_data_out), 32'h0);
        chk("t1_valid", 32'(bus0.o_out_valid), 32'h0);
        chk("t1_busy", 32'(bus0.o_busy), 32'h0);
        chk("t1_flags", 32'({bus0.o_overrun, bus0.o_frame_err}), 32'h0);
        chk("t1_state", 32'(state0), 32'(ST_IDLE));

        // 2. Basic frame 0x7B, consumer always ready
        cycle(1, 0, 0, 0, 1, 0);
        send_word(8'h7B, 1);
        chk("t2_valid", 32'(bus0.o_out_valid), 32'h1);
        chk("t2_data_msb", 32'(bus0.o_data_out), 32'h7B);
        chk("t2_data_lsb", 32'(bus1.o_data_out), 32'hDE);
        cycle(1, 0, 0, 0, 1, 0);
        chk("t2_valid_drop", 32'(bus0.o_out_valid), 32'h0);
        chk("t2_data_hold", 32'(bus0.o_data_out), 32'h7B);

        // 3. Stall for 3 cycles after bit 4
        w = 8'h7B;
        for (int i = 0; i < 5; i++) cycle(1, 1, w[7-i], i == 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1, 1, 1, 0);
            chk("t3_busy_stall", 32'(bus0.o_busy), 32'h1);
        end
        for (int i = 5; i < 8; i++) cycle(1, 1, w[7-i], 0, 1, 0);
        chk("t3_data", 32'(bus0.o_data_out), 32'h7B);
        chk("t3_valid", 32'(bus0.o_out_valid), 32'h1);

        // 4. Overrun with consumer stalled, then clear
        cycle(1, 0, 0, 0, 1, 0);
        send_word(8'hA5, 0);
        chk("t4_first", 32'(bus0.o_data_out), 32'hA5);
        send_word(8'h3C, 0);
        chk("t4_hold", 32'(bus0.o_data_out), 32'hA5);
        chk("t4_overrun", 32'(bus0.o_overrun), 32'h1);
        cycle(1, 0, 0, 0, 0, 1);
        chk("t4_clr", 32'(bus0.o_overrun), 32'h0);
        chk("t4_still_valid", 32'(bus0.o_out_valid), 32'h1);
        cycle(1, 0, 0, 0, 1, 0);

        // 5. Frame start at bit 5, then 0x81
        w = 8'h5A;
        for (int i = 0; i < 5; i++) cycle(1, 1, w[7-i], i == 0, 1, 0);
        send_word(8'h81, 1);
        chk("t5_frame_err", 32'(bus0.o_frame_err), 32'h1);
        chk("t5_data", 32'(bus0.o_data_out), 32'h81);
        cycle(1, 0, 0, 0, 1, 1);
        chk("t5_clr", 32'(bus0.o_frame_err), 32'h0);

        // 6. Reset mid-frame, then 0xFF
        w = 8'h00;
        for (int i = 0; i < 4; i++) cycle(1, 1, w[7-i], i == 0, 1, 0);
        cycle(0, 1, 1, 0, 1, 0);
        send_word(8'hFF, 1);
        chk("t6_data", 32'(bus0.o_data_out), 32'hFF);
        chk("t6_flags", 32'({bus0.o_overrun, bus0.o_frame_err}), 32'h0);

        // Random run
        for (int c = 0; c < 5000; c++) begin
            r   = ($urandom_range(0, 499) != 0);
            en  = ($urandom_range(0, 3) != 0);
            sin = 1'($urandom);
            fs  = ($urandom_range(0, 11) == 0);
            rdy = 1'($urandom);
            clr = ($urandom_range(0, 49) == 0);
            cycle(r, en, sin, fs, rdy, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
